// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and defaults for the memory-stage sequencer.
package mem_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_RD_W   = 5;

  // Decoded memory operation coming from execute.
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4,
    OP_CALL  = 3'd5,
    OP_RET   = 3'd6,
    OP_RSVD  = 3'd7
  } op_t;

  // Exception reported with the response.
  typedef enum logic [1:0] {
    EXC_NONE = 2'd0,
    EXC_OVF  = 2'd1,
    EXC_UNF  = 2'd2,
    EXC_ADDR = 2'd3
  } exc_t;

  // Sequencer state; every request walks all four states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request, response and memory-side bus of the memory-stage sequencer.
// Handshake: a request transfers on the rising edge where req_valid and
// req_ready are both high; req_* must be stable while req_valid is high and
// are sampled only on that edge. resp_valid is a one-cycle pulse with no
// back-pressure; redir_valid and exc_valid are qualified by resp_valid.
interface mem_access_ctrl_if
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [RD_W-1:0]   req_rd;

  logic [DATA_W-1:0] address;
  logic [DATA_W-1:0] dataIn;
  logic              memoR;
  logic              memoWR;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] dataOut;
  logic              emptyStack;
  logic              fullStack;

  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic [RD_W-1:0]   resp_rd;
  logic              resp_wb;
  logic              redir_valid;
  logic [DATA_W-1:0] redir_pc;
  logic              exc_valid;
  logic [1:0]        exc_code;

  // Controller side.
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rd,
    input  dataOut, emptyStack, fullStack,
    output req_ready, address, dataIn, memoR, memoWR, push, pop,
    output resp_valid, resp_data, resp_rd, resp_wb,
    output redir_valid, redir_pc, exc_valid, exc_code
  );

  // Execute stage plus memory side.
  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rd,
    output dataOut, emptyStack, fullStack,
    input  req_ready, address, dataIn, memoR, memoWR, push, pop,
    input  resp_valid, resp_data, resp_rd, resp_wb,
    input  redir_valid, redir_pc, exc_valid, exc_code
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-stage sequencer: one request at a time, fixed IDLE/ISSUE/WAIT/RESP
// timing, registered memory strobes, one-cycle response pulse.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_W   = DEF_RD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_ctrl_if.slave bus,
  output state_t           o_state
);

  state_t            r_state, w_next;
  op_t               r_op;
  exc_t              r_exc;
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [RD_W-1:0]   r_rd;
  logic              r_memoR, r_memoWR, r_push, r_pop;
  logic [DATA_W-1:0] r_address, r_dataIn;

  op_t  w_op;
  exc_t w_exc;
  logic w_accept;
  logic w_ok;
  logic w_resp;
  logic w_lat_ok;

  assign w_op     = op_t'(bus.req_op);
  assign w_accept = (r_state == ST_IDLE) && bus.req_valid;
  assign w_ok     = (w_exc == EXC_NONE);
  assign w_resp   = (r_state == ST_RESP);
  assign w_lat_ok = (r_exc == EXC_NONE);

  // Classify the incoming request using the stack flags seen at accept.
  always_comb begin
    w_exc = EXC_NONE;
    case (w_op)
      OP_PUSH, OP_CALL: if (bus.fullStack)  w_exc = EXC_OVF;
      OP_POP,  OP_RET:  if (bus.emptyStack) w_exc = EXC_UNF;
      OP_LOAD, OP_STORE:
        if (bus.req_addr[DATA_W-1:ADDR_W] != '0) w_exc = EXC_ADDR;
      OP_RSVD:          w_exc = EXC_ADDR;
      default:          w_exc = EXC_NONE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state: a fixed walk once a request is taken.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Latch the request fields and its exception class at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= OP_NOP;
      r_exc  <= EXC_NONE;
      r_addr <= '0;
      r_rd   <= '0;
    end else if (w_accept) begin
      r_op   <= w_op;
      r_exc  <= w_exc;
      r_addr <= bus.req_addr;
      r_rd   <= bus.req_rd;
    end
  end

  // Strobes are set on the accept edge so they cover exactly the ISSUE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_memoR  <= 1'b0;
      r_memoWR <= 1'b0;
      r_push   <= 1'b0;
      r_pop    <= 1'b0;
    end else begin
      r_memoR  <= 1'b0;
      r_memoWR <= 1'b0;
      r_push   <= 1'b0;
      r_pop    <= 1'b0;
      if (w_accept && w_ok) begin
        case (w_op)
          OP_LOAD:          r_memoR  <= 1'b1;
          OP_STORE:         r_memoWR <= 1'b1;
          OP_PUSH, OP_CALL: r_push   <= 1'b1;
          OP_POP,  OP_RET:  r_pop    <= 1'b1;
          default:          r_memoR  <= 1'b0;
        endcase
      end
    end
  end

  // Address/data buses hold from ISSUE through RESP and return to 0 in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_address <= '0;
      r_dataIn  <= '0;
    end else if (w_accept) begin
      r_address <= (w_ok && (w_op == OP_LOAD || w_op == OP_STORE)) ? bus.req_addr : '0;
      r_dataIn  <= (w_ok && (w_op == OP_STORE || w_op == OP_PUSH || w_op == OP_CALL))
                   ? bus.req_wdata : '0;
    end else if (w_resp) begin
      r_address <= '0;
      r_dataIn  <= '0;
    end
  end

  // Capture read data: stack top is live during ISSUE, memory data during WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (w_accept) begin
      r_data <= '0;
    end else if (w_lat_ok && r_state == ST_ISSUE && (r_op == OP_POP || r_op == OP_RET)) begin
      r_data <= bus.dataOut;
    end else if (w_lat_ok && r_state == ST_WAIT && r_op == OP_LOAD) begin
      r_data <= bus.dataOut;
    end
  end

  assign bus.req_ready   = (r_state == ST_IDLE);
  assign bus.memoR       = r_memoR;
  assign bus.memoWR      = r_memoWR;
  assign bus.push        = r_push;
  assign bus.pop         = r_pop;
  assign bus.address     = r_address;
  assign bus.dataIn      = r_dataIn;

  assign bus.resp_valid  = w_resp;
  assign bus.resp_data   = w_resp ? r_data : '0;
  assign bus.resp_rd     = w_resp ? r_rd : '0;
  assign bus.resp_wb     = w_resp && w_lat_ok && (r_op == OP_LOAD || r_op == OP_POP);
  assign bus.redir_valid = w_resp && w_lat_ok && (r_op == OP_CALL || r_op == OP_RET);
  assign bus.redir_pc    = !bus.redir_valid ? '0 : ((r_op == OP_CALL) ? r_addr : r_data);
  assign bus.exc_valid   = w_resp && !w_lat_ok;
  assign bus.exc_code    = w_resp ? r_exc : EXC_NONE;

  assign o_state = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: memory/stack model, abstract reference model,
// per-cycle compare process and directed scenarios.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int RW    = 5;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mem_rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_ctrl_if #(.DATA_W(DW), .RD_W(RW)) bus ();
  state_t dbg_state;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_W(RW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // ---------------- memory + stack behaviour ----------------
  logic [DW-1:0] mem_arr [0:(1<<AW)-1];
  logic [DW-1:0] stk [0:DEPTH-1];
  logic [2:0]    sp;
  logic [DW-1:0] rd_q;
  logic          rd_pend;

  always @(posedge clk or negedge mem_rst_n) begin
    if (!mem_rst_n) begin
      sp      <= 3'd0;
      rd_q    <= '0;
      rd_pend <= 1'b0;
    end else begin
      if (bus.memoWR) mem_arr[bus.address[AW-1:0]] <= bus.dataIn;
      if (bus.memoR)  rd_q <= mem_arr[bus.address[AW-1:0]];
      rd_pend <= bus.memoR;
      if (bus.push && sp < 3'd4) begin
        stk[sp[1:0]] <= bus.dataIn;
        sp <= sp + 3'd1;
      end
      if (bus.pop && sp != 3'd0) sp <= sp - 3'd1;
    end
  end

  assign bus.dataOut    = rd_pend ? rd_q : ((sp != 3'd0) ? stk[sp[1:0] - 2'd1] : '0);
  assign bus.emptyStack = (sp == 3'd0);
  assign bus.fullStack  = (sp == 3'd4);

  // ---------------- reference model ----------------
  typedef struct {
    int            acc;
    logic [3:0]    strb;   // {memoR, memoWR, push, pop} during ISSUE
    logic          chk_addr;
    logic [DW-1:0] addr;
    logic          chk_din;
    logic [DW-1:0] din;
    logic [DW-1:0] data;
    logic [RW-1:0] rd;
    logic          wb;
    logic          redir;
    logic [DW-1:0] pc;
    logic [1:0]    code;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] ref_stk[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_rd = 0, n_wr = 0, n_push = 0, n_pop = 0;
  logic [DW-1:0] last_data, last_pc;
  logic [RW-1:0] last_rd;
  logic          last_wb, last_redir, last_exc;
  logic [1:0]    last_code;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // What a request must produce, from the operation rules alone.
  function automatic exp_t model(input logic [2:0] op, input logic [DW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [RW-1:0] rd,
                                 input int acc);
    exp_t e;
    logic [DW-1:0] hi;
    e = '{default: '0};
    e.acc = acc;
    e.rd  = rd;
    hi = addr >> AW;
    if ((op == 3'd1 || op == 3'd2) && hi != 0)                   e.code = 2'd3;
    else if ((op == 3'd3 || op == 3'd5) && ref_stk.size() >= DEPTH) e.code = 2'd1;
    else if ((op == 3'd4 || op == 3'd6) && ref_stk.size() == 0)  e.code = 2'd2;
    else if (op == 3'd7)                                         e.code = 2'd3;
    if (e.code == 2'd0) begin
      case (op)
        3'd1: begin
          e.strb = 4'b1000; e.chk_addr = 1'b1; e.addr = addr;
          e.data = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : '0;
        end
        3'd2: begin
          e.strb = 4'b0100; e.chk_addr = 1'b1; e.addr = addr;
          e.chk_din = 1'b1; e.din = wdata;
          ref_mem[int'(addr)] = wdata;
        end
        3'd3, 3'd5: begin
          e.strb = 4'b0010; e.chk_din = 1'b1; e.din = wdata;
          ref_stk.push_back(wdata);
        end
        3'd4, 3'd6: begin
          e.strb = 4'b0001;
          e.data = ref_stk.pop_back();
        end
        default: e.strb = 4'b0000;
      endcase
      e.wb    = (op == 3'd1 || op == 3'd4);
      e.redir = (op == 3'd5 || op == 3'd6);
      e.pc    = (op == 3'd5) ? addr : e.data;
    end
    return e;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin : cmp
    int   phase;
    exp_t t;
    if (rst_n) begin
      phase = 0;
      t = '{default: '0};
      if (exp_q.size() > 0) begin
        t = exp_q[0];
        if (cyc >= t.acc && cyc <= t.acc + 2) phase = cyc - t.acc + 1;
      end
      if (bus.memoR)  n_rd++;
      if (bus.memoWR) n_wr++;
      if (bus.push)   n_push++;
      if (bus.pop)    n_pop++;
      check("req_ready", {31'd0, bus.req_ready}, {31'd0, phase == 0});
      check("strobes", {28'd0, bus.memoR, bus.memoWR, bus.push, bus.pop},
            {28'd0, (phase == 1) ? t.strb : 4'b0000});
      if (phase == 0) begin
        check("idle_address", bus.address, '0);
        check("idle_dataIn", bus.dataIn, '0);
      end else begin
        if (t.chk_addr) check("address", bus.address, t.addr);
        if (t.chk_din)  check("dataIn", bus.dataIn, t.din);
      end
      check("resp_valid", {31'd0, bus.resp_valid}, {31'd0, phase == 3});
      check("redir_valid", {31'd0, bus.redir_valid}, {31'd0, phase == 3 && t.redir});
      check("exc_valid", {31'd0, bus.exc_valid}, {31'd0, phase == 3 && t.code != 2'd0});
      check("exc_code", {30'd0, bus.exc_code}, {30'd0, (phase == 3) ? t.code : 2'd0});
      if (phase == 3) begin
        check("resp_rd", {27'd0, bus.resp_rd}, {27'd0, t.rd});
        check("resp_wb", {31'd0, bus.resp_wb}, {31'd0, t.wb});
        if (t.wb)    check("resp_data", bus.resp_data, t.data);
        if (t.redir) check("redir_pc", bus.redir_pc, t.pc);
        last_data  = bus.resp_data;
        last_pc    = bus.redir_pc;
        last_rd    = bus.resp_rd;
        last_wb    = bus.resp_wb;
        last_redir = bus.redir_valid;
        last_exc   = bus.exc_valid;
        last_code  = bus.exc_code;
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [DW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [RW-1:0] rd, output int acc);
    int k;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_rd    = rd;
    bus.req_valid = 1'b1;
    k = 0;
    while (!bus.req_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    exp_q.push_back(model(op, addr, wdata, rd, acc));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() > 0) begin
      check("resp_timeout", 32'd0, 32'd1);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_op(input logic [2:0] op, input logic [DW-1:0] addr,
                       input logic [DW-1:0] wdata, input logic [RW-1:0] rd);
    int a;
    send(op, addr, wdata, rd, a);
    wait_idle();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int a1, a2, a3, pops0, rd0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_rd    = '0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_strobes", {28'd0, bus.memoR, bus.memoWR, bus.push, bus.pop}, 32'd0);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_address", bus.address, 32'd0);
    rst_n = 1'b1;
    mem_rst_n = 1'b1;
    @(negedge clk);

    // store then load back
    do_op(3'd2, 32'd5, 32'hDEAD_BEEF, 5'd0);
    do_op(3'd1, 32'd5, 32'd0, 5'd3);
    check("load_data_lit", last_data, 32'hDEAD_BEEF);
    check("load_rd_lit", {27'd0, last_rd}, 32'd3);
    check("load_wb_lit", {31'd0, last_wb}, 32'd1);
    check("memoWR_cycles", n_wr, 32'd1);
    check("memoR_cycles", n_rd, 32'd1);

    // push then pop
    do_op(3'd3, 32'd0, 32'd42, 5'd0);
    do_op(3'd4, 32'd0, 32'd0, 5'd7);
    check("pop_data_lit", last_data, 32'd42);
    check("pop_empty_after", {31'd0, bus.emptyStack}, 32'd1);

    // call then return
    do_op(3'd5, 32'h100, 32'h24, 5'd0);
    check("call_pc_lit", last_pc, 32'h100);
    check("call_redir_lit", {31'd0, last_redir}, 32'd1);
    pops0 = n_pop;
    do_op(3'd6, 32'd0, 32'd0, 5'd9);
    check("ret_pc_lit", last_pc, 32'h24);
    check("ret_wb_lit", {31'd0, last_wb}, 32'd0);
    check("ret_pop_once", n_pop - pops0, 32'd1);

    // underflow, bad address, reserved op, NOP
    pops0 = n_pop;
    do_op(3'd4, 32'd0, 32'd0, 5'd1);
    check("unf_code_lit", {30'd0, last_code}, 32'd2);
    check("unf_exc_lit", {31'd0, last_exc}, 32'd1);
    check("unf_no_pop", n_pop - pops0, 32'd0);
    check("unf_empty", {31'd0, bus.emptyStack}, 32'd1);
    rd0 = n_rd;
    do_op(3'd1, 32'h200, 32'd0, 5'd2);
    check("badaddr_code_lit", {30'd0, last_code}, 32'd3);
    check("badaddr_no_memoR", n_rd - rd0, 32'd0);
    do_op(3'd7, 32'd0, 32'd0, 5'd4);
    check("rsvd_code_lit", {30'd0, last_code}, 32'd3);
    do_op(3'd0, 32'd0, 32'd0, 5'd6);
    check("nop_wb_lit", {31'd0, last_wb}, 32'd0);

    // fill the stack, then overflow on push and call
    do_op(3'd3, 32'd0, 32'd11, 5'd0);
    do_op(3'd3, 32'd0, 32'd22, 5'd0);
    do_op(3'd3, 32'd0, 32'd33, 5'd0);
    do_op(3'd3, 32'd0, 32'd44, 5'd0);
    do_op(3'd3, 32'd0, 32'd55, 5'd0);
    check("ovf_push_code_lit", {30'd0, last_code}, 32'd1);
    do_op(3'd5, 32'h40, 32'h8, 5'd0);
    check("ovf_call_code_lit", {30'd0, last_code}, 32'd1);
    do_op(3'd4, 32'd0, 32'd0, 5'd8);
    check("pop_top_lit", last_data, 32'd44);

    // back-to-back requests with req_valid held high
    send(3'd2, 32'd10, 32'h1234_5678, 5'd0, a1);
    send(3'd2, 32'd11, 32'h0BAD_F00D, 5'd0, a2);
    send(3'd1, 32'd10, 32'd0, 5'd12, a3);
    wait_idle();
    check("b2b_gap1", a2 - a1, 32'd4);
    check("b2b_gap2", a3 - a2, 32'd4);
    check("b2b_load_lit", last_data, 32'h1234_5678);

    // reset during WAIT of a LOAD
    send(3'd1, 32'd11, 32'd0, 5'd5, a1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rstw_strobes", {28'd0, bus.memoR, bus.memoWR, bus.push, bus.pop}, 32'd0);
    check("rstw_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_ready_after", {31'd0, bus.req_ready}, 32'd1);
    repeat (4) @(negedge clk);

    // reset during ISSUE of a STORE: the strobe must drop at once
    send(3'd2, 32'd20, 32'h5555_AAAA, 5'd0, a1);
    #1;
    check("rsti_memoWR_before", {31'd0, bus.memoWR}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rsti_memoWR_after", {31'd0, bus.memoWR}, 32'd0);
    check("rsti_address", bus.address, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // controller still works after reset
    do_op(3'd1, 32'd11, 32'd0, 5'd13);
    check("post_rst_load_lit", last_data, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage sequencer that sits directly upstream of the data memory/stack block.
- Accepts one decoded memory request at a time from execute: load, store, push, pop, call, ret.
- Drives the memory's address, dataIn, memoR, memoWR, push and pop strobes with fixed timing, and captures dataOut.
- Returns a writeback/redirect response, or an exception for stack overflow/underflow and bad address.

Parameters:
- ADDR_W, 9, number of implemented word-address bits (memory has 2^ADDR_W words).
- DATA_W, 32, data and address bus width.
- RD_W, 5, destination register tag width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  3  0 NOP, 1 LOAD, 2 STORE, 3 PUSH, 4 POP, 5 CALL, 6 RET, 7 reserved.
- req_addr  in  DATA_W  LOAD/STORE word address; CALL target.
- req_wdata  in  DATA_W  STORE/PUSH data; CALL return address.
- req_rd  in  RD_W  destination tag, echoed in the response.
- address  out  DATA_W  to memory.
- dataIn  out  DATA_W  to memory.
- memoR, memoWR, push, pop  out  1 each  memory strobes, registered.
- dataOut  in  DATA_W  memory read / stack-top data.
- emptyStack, fullStack  in  1  memory stack flags.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  DATA_W  loaded or popped value.
- resp_rd  out  RD_W  echoed tag.
- resp_wb  out  1  resp_data must be written to resp_rd.
- redir_valid  out  1  PC redirect, qualified by resp_valid.
- redir_pc  out  DATA_W  redirect target.
- exc_valid  out  1  exception, qualified by resp_valid.
- exc_code  out  2  0 none, 1 stack overflow, 2 stack underflow, 3 bad address/op.

Behaviour:
- Reset (asynchronous): FSM goes to IDLE. All outputs are 0 except req_ready=1. Strobes drop immediately.
- Reset mid-operation: the operation is abandoned and no response is produced. A memory write or stack move already committed on an earlier edge is not undone.
- FSM states and transitions: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- Accept: in IDLE, req_ready=1; it is 0 in every other state. A request is accepted at the edge where req_valid && req_ready, and req_* fields are latched.
- NOP acceptance: NOP is accepted and gets a response with resp_wb=0. It issues no strobes.
- Latency: accept at edge T. ISSUE covers cycle T+1, WAIT covers T+2, and resp_valid is high for exactly cycle T+3. Throughput is one request per 4 cycles.
- Error check at accept, using flags sampled on the accept edge:
  - PUSH or CALL with fullStack=1 -> overflow.
  - POP or RET with emptyStack=1 -> underflow.
  - LOAD or STORE with req_addr[DATA_W-1:ADDR_W]!=0 -> code 3.
  - op 7 -> code 3.
- Erroring requests still walk ISSUE/WAIT/RESP but assert no strobe. The response has exc_valid=1, resp_wb=0, redir_valid=0.
- Strobes: at most one strobe is high in any cycle, and only during ISSUE.
  - LOAD: memoR=1, address=req_addr.
  - STORE: memoWR=1, address=req_addr, dataIn=req_wdata.
  - PUSH: push=1, dataIn=req_wdata.
  - CALL: push=1, dataIn=req_wdata.
  - POP/RET: pop=1.
  - address and dataIn hold their values from ISSUE through RESP and are 0 in IDLE.
- Data capture into resp_data:
  - POP/RET: captured at the end of ISSUE. This is the pre-pop stack top, which the memory presents combinationally on dataOut.
  - LOAD: captured at the end of WAIT, because memory read data is registered on the ISSUE edge.
- Response contents:
  - LOAD/POP: resp_wb=1.
  - CALL: redir_valid=1, redir_pc=latched req_addr.
  - RET: redir_valid=1, redir_pc=captured stack top, resp_wb=0.
  - STORE/PUSH: resp_valid only, as an acknowledge.
- Outside RESP: resp_valid, redir_valid and exc_valid are 0, and exc_code is 0.
- Simultaneous events: req_valid is ignored outside IDLE, and requests are never queued. Flag changes after accept are ignored.
- Push count: a full push/pop round trip leaves the memory sp unchanged. The controller never issues more than one stack move per request.

Decomposition:
- Shared package mem_pkg holds:
  - op enum: OP_NOP..OP_RET.
  - exc_code enum: EXC_NONE, EXC_OVF, EXC_UNF, EXC_ADDR.
  - FSM state enum.
  - ADDR_W/DATA_W defaults.
- No sub-module. The FSM, the request latch and the response register fit in one module.

Test Plan:
- STORE addr=5 data=0xDEAD_BEEF, then LOAD addr=5 rd=3 -> LOAD response at T+3 with resp_data=0xDEADBEEF, resp_wb=1, resp_rd=3. memoWR and memoR are each high exactly one cycle.
- PUSH 42, then POP rd=7 -> POP response resp_data=42, resp_wb=1. emptyStack=1 afterwards.
- CALL req_addr=0x100 wdata=0x24, then RET -> CALL gives redir_pc=0x100; RET gives redir_pc=0x24 and pop pulsed once.
- POP on an empty stack -> exc_valid=1, exc_code=2, no pop strobe, emptyStack still 1. LOAD addr=0x200 -> exc_code=3, no memoR.
- Back-to-back req_valid held high -> req_ready low for 3 cycles; requests accepted every 4th cycle; one strobe per ISSUE.
- Assert rst_n=0 during WAIT of a LOAD -> all strobes and resp_valid go 0 immediately, no response after release, req_ready=1 on the next cycle.
